fme_saida_serial: RTL and testbench
===================================

Name: fme_saida_serial

Overview:
- Consumer-side companion of the FME interpolator.
- Captures the full set of N_SAMPLES interpolated samples when the interpolator pulses done.
- Streams the captured samples to downstream logic (SAD/cost unit or memory writer) as LANES samples per beat over a valid/ready handshake.
- Decouples the interpolator's parallel output from the narrow downstream datapath.

Parameters:
DATA_WIDTH, 8, bits per sample
N_SAMPLES, 162, samples per interpolation result
LANES, 4, samples per output beat (N_BEATS = ceil(N_SAMPLES/LANES) = 41 at defaults)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
fme_done  input  1  one-cycle pulse from interpolator: samples valid this cycle
fme_samples  input  N_SAMPLES*DATA_WIDTH  flattened samples; sample i at bits [i*DATA_WIDTH +: DATA_WIDTH]
out_valid  output  1  beat available
out_ready  input  1  downstream accepts beat
out_data  output  LANES*DATA_WIDTH  lane j = sample beat*LANES+j, lane 0 at LSBs
out_keep  output  LANES  per-lane valid mask
out_last  output  1  final beat of a result
busy  output  1  capture register occupied (SEND state)
clear_erro  input  1  synchronous clear of overrun
overrun  output  1  sticky: fme_done arrived with no free buffer

Behaviour:
- Reset (reset=0, async): state=IDLE, beat counter=0, out_valid=0, out_data=0, out_keep=0, out_last=0, busy=0, overrun=0, capture contents cleared. Reset mid-frame aborts the frame; no partial beats after release.
- States:
  - IDLE: out_valid=0. On fme_done, latch fme_samples into capture register, beat=0, go to SEND next cycle.
  - SEND: out_valid=1, busy=1. On out_valid&out_ready, beat++. On transfer of beat N_BEATS-1, return to IDLE (or reload, see optional feature).
- Latency: fme_done at cycle t -> out_valid=1 with beat 0 at cycle t+1.
- Throughput: one beat per cycle while out_ready=1.
- Handshake:
  - out_data, out_keep and out_last are stable while out_valid=1 and out_ready=0.
  - out_valid never deasserts before the beat transfers.
- Beat contents:
  - out_keep = all ones except on the last beat, where out_keep has (N_SAMPLES mod LANES) low bits set (all ones if the remainder is 0).
  - Unused lanes on the last beat drive 0.
  - out_last=1 only on beat N_BEATS-1.
- Outputs are registered or derived from registered state only. No combinational path from out_ready to out_valid.
- The beat counter is sized ceil(log2(N_BEATS)). It is never exceeded; the counter resets to 0 on frame completion.
- overrun:
  - Set when fme_done=1 and no buffer is free. The new samples are discarded and the current frame is unaffected.
  - Cleared by clear_erro=1.
  - If set and clear happen in the same cycle, set wins.
- Simultaneous final-beat transfer and fme_done in SEND: not an overrun. New samples are captured and SEND restarts at beat 0 on the next cycle (back-to-back frames, no idle cycle).

Optional Feature:
FME_SAIDA_DOUBLE_BUF_EN
- Defined:
  - Adds a second pending register. fme_done during SEND (not the final transfer) latches into the pending register.
  - At final-beat transfer, the pending register moves to the capture register and SEND restarts at beat 0 with no gap.
  - overrun is set only if fme_done arrives while the pending register is already full.
- Undefined:
  - Single buffer only. Any fme_done during SEND, other than on the final-beat transfer cycle, sets overrun and is dropped.

Test Plan:
- Basic frame: sample i = i mod 256, pulse fme_done, out_ready=1 constant -> 41 beats on consecutive cycles.
  - Beat 0 out_data=0x03020100, out_keep=4'b1111.
  - Beat 40 out_data=0x0000A1A0, out_keep=4'b0011, out_last=1.
  - out_valid=0 and busy=0 on the following cycle.
- Backpressure: toggle out_ready 1,0,0,1 each beat -> no beat lost or duplicated, outputs hold while stalled, 41 transfers total, same data as the basic frame.
- Overrun (macro undefined): second fme_done at beat 10 with samples=0xFF -> overrun=1, remaining beats still carry the first frame. clear_erro=1 -> overrun=0 next cycle.
- Back-to-back: fme_done coincident with the beat-40 transfer -> next cycle beat 0 of the new frame, out_valid stays 1.
- Reset mid-frame: assert reset at beat 20 -> all outputs 0 immediately. After release, out_valid stays 0 until the next fme_done.
- Double buffer (macro defined): fme_done at beats 5 and 30 -> first sets pending, second sets overrun=1. 82 beats delivered contiguously when out_ready=1.

Source files
------------

// File: rtl/fme_saida_serial_if.sv
// Capture/stream bundle between the FME interpolator, this serializer and the downstream beat consumer.
// The slave modport is the serializer's view; the master modport is the producer/consumer environment.
interface fme_saida_serial_if #(
    parameter int DATA_WIDTH = 8,
    parameter int N_SAMPLES  = 162,
    parameter int LANES      = 4
);
    logic                            fme_done;
    logic [N_SAMPLES*DATA_WIDTH-1:0] fme_samples;
    logic                            out_valid;
    logic                            out_ready;
    logic [LANES*DATA_WIDTH-1:0]     out_data;
    logic [LANES-1:0]                out_keep;
    logic                            out_last;
    logic                            busy;
    logic                            clear_erro;
    logic                            overrun;

    modport slave (
        input  fme_done,
        input  fme_samples,
        input  out_ready,
        input  clear_erro,
        output out_valid,
        output out_data,
        output out_keep,
        output out_last,
        output busy,
        output overrun
    );

    modport master (
        output fme_done,
        output fme_samples,
        output out_ready,
        output clear_erro,
        input  out_valid,
        input  out_data,
        input  out_keep,
        input  out_last,
        input  busy,
        input  overrun
    );
endinterface

// File: rtl/fme_saida_serial.sv
// Serializes one interpolation result into LANES-sample beats; FME_SAIDA_DOUBLE_BUF_EN adds a pending buffer.
// Latency: fme_done at t -> beat 0 valid at t+1; one beat per cycle while out_ready is high.
// Backpressure: beat held stable under out_ready=0; fme_done with no free buffer is dropped and sets overrun.
module fme_saida_serial #(
    parameter int DATA_WIDTH = 8,
    parameter int N_SAMPLES  = 162,
    parameter int LANES      = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    fme_saida_serial_if.slave     bus
);
    localparam int N_BEATS   = (N_SAMPLES + LANES - 1) / LANES;
    localparam int BEAT_W    = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam int REM       = N_SAMPLES % LANES;
    localparam int BEAT_BITS = LANES * DATA_WIDTH;
    localparam int SMP_W     = N_SAMPLES * DATA_WIDTH;
    localparam int CAP_W     = N_BEATS * BEAT_BITS;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_BEATS - 1);
    localparam logic [LANES-1:0]  LAST_KEEP = (REM == 0) ? {LANES{1'b1}} : LANES'((1 << REM) - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [BEAT_W-1:0]   r_beat;
    logic [CAP_W-1:0]    r_cap;
    logic                r_ovr;

    logic                w_send;
    logic                w_is_last;
    logic                w_xfer;
    logic                w_final;
    logic                w_load_new;
    logic                w_load_pend;
    logic                w_shift;
    logic                w_beat_clr;
    logic                w_ovr_set;
    logic                w_pend_wr;
    logic                w_pend_clr;
    logic                w_pend_full;
    logic [CAP_W-1:0]    w_new_pad;
    logic [CAP_W-1:0]    w_pend_pad;

    // Zero padding past the last sample makes the unused lanes of the final beat read as 0.
    always_comb begin
        w_new_pad              = '0;
        w_new_pad[SMP_W-1:0]   = bus.fme_samples;
    end

`ifdef FME_SAIDA_DOUBLE_BUF_EN
    logic [SMP_W-1:0]    r_pend;
    logic                r_pend_full;

    always_comb begin
        w_pend_pad             = '0;
        w_pend_pad[SMP_W-1:0]  = r_pend;
    end

    assign w_pend_full = r_pend_full;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pend      <= '0;
            r_pend_full <= 1'b0;
        end else begin
            if (w_pend_wr) begin
                r_pend <= bus.fme_samples;
            end
            if (w_pend_wr) begin
                r_pend_full <= 1'b1;
            end else if (w_pend_clr) begin
                r_pend_full <= 1'b0;
            end
        end
    end
`else
    assign w_pend_pad  = '0;
    assign w_pend_full = 1'b0;
`endif

    assign w_send    = (r_state == S_SEND);
    assign w_is_last = (r_beat == LAST_BEAT);
    assign w_xfer    = w_send & bus.out_ready;
    assign w_final   = w_xfer & w_is_last;

    always_comb begin
        w_state_nxt = r_state;
        w_load_new  = 1'b0;
        w_load_pend = 1'b0;
        w_shift     = 1'b0;
        w_beat_clr  = 1'b0;
        w_ovr_set   = 1'b0;
        w_pend_wr   = 1'b0;
        w_pend_clr  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.fme_done) begin
                    w_load_new  = 1'b1;
                    w_beat_clr  = 1'b1;
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (w_final) begin
                    w_beat_clr = 1'b1;
                    // A waiting result takes priority; a coincident fme_done then refills the pending slot.
                    if (w_pend_full) begin
                        w_load_pend = 1'b1;
                        if (bus.fme_done) begin
                            w_pend_wr  = 1'b1;
                        end else begin
                            w_pend_clr = 1'b1;
                        end
                    end else if (bus.fme_done) begin
                        w_load_new = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_shift = w_xfer;
                    if (bus.fme_done) begin
`ifdef FME_SAIDA_DOUBLE_BUF_EN
                        if (w_pend_full) begin
                            w_ovr_set = 1'b1;
                        end else begin
                            w_pend_wr = 1'b1;
                        end
`else
                        w_ovr_set = 1'b1;
`endif
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_beat  <= '0;
            r_cap   <= '0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_beat_clr) begin
                r_beat <= '0;
            end else if (w_shift) begin
                r_beat <= r_beat + BEAT_W'(1);
            end

            // The current beat always sits in the low lanes; each transfer shifts the next one down.
            if (w_load_new) begin
                r_cap <= w_new_pad;
            end else if (w_load_pend) begin
                r_cap <= w_pend_pad;
            end else if (w_shift) begin
                r_cap <= r_cap >> BEAT_BITS;
            end

            if (w_ovr_set) begin
                r_ovr <= 1'b1;
            end else if (bus.clear_erro) begin
                r_ovr <= 1'b0;
            end
        end
    end

    assign bus.out_valid = w_send;
    assign bus.out_data  = w_send ? r_cap[BEAT_BITS-1:0] : '0;
    assign bus.out_keep  = w_send ? (w_is_last ? LAST_KEEP : {LANES{1'b1}}) : '0;
    assign bus.out_last  = w_send & w_is_last;
    assign bus.busy      = w_send;
    assign bus.overrun   = r_ovr;
endmodule

// File: tb/tb_fme_saida_serial.sv
// Directed bench for fme_saida_serial: basic frame, backpressure, overrun, back-to-back and reset abort.
// The double-buffer sequence replaces the single-buffer overrun sequence when FME_SAIDA_DOUBLE_BUF_EN is defined.
module tb_fme_saida_serial;
    localparam int DW = 8;
    localparam int NS = 162;
    localparam int L  = 4;
    localparam int NB = 41;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    fme_saida_serial_if #(.DATA_WIDTH(DW), .N_SAMPLES(NS), .LANES(L)) bus ();

    fme_saida_serial #(.DATA_WIDTH(DW), .N_SAMPLES(NS), .LANES(L)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        int          beat;
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } vec_t;

    vec_t vecs [5];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_data(input int base, input int b);
        logic [31:0] d;
        int idx;
        d = '0;
        for (int j = 0; j < L; j++) begin
            idx = b * L + j;
            if (idx < NS) d[j*DW +: DW] = 8'((idx + base) % 256);
        end
        return d;
    endfunction

    function automatic logic [3:0] exp_keep(input int b);
        return (b == NB - 1) ? 4'b0011 : 4'b1111;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input int base, input bit all_ff);
        for (int i = 0; i < NS; i++) begin
            bus.fme_samples[i*DW +: DW] = all_ff ? 8'hFF : 8'((i + base) % 256);
        end
    endtask

    task automatic start_frame(input int base);
        load(base, 1'b0);
        bus.fme_done = 1'b1;
        tick();
        bus.fme_done = 1'b0;
    endtask

    task automatic check_beat(input string tag, input int base, input int b);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, "_data"},  64'(bus.out_data),  64'(exp_data(base, b)));
        check({tag, "_keep"},  64'(bus.out_keep),  64'(exp_keep(b)));
        check({tag, "_last"},  64'(bus.out_last),  64'(b == NB - 1));
    endtask

    initial begin
        bit [3:0]    pat;
        int          nx;
        int          cyc;
        bit          stalled;
        logic [31:0] held_d;
        logic [3:0]  held_k;
        logic        held_l;

        bus.fme_done    = 1'b0;
        bus.out_ready   = 1'b0;
        bus.clear_erro  = 1'b0;
        bus.fme_samples = '0;

        vecs[0] = '{beat: 0,  data: 32'h03020100, keep: 4'b1111, last: 1'b0};
        vecs[1] = '{beat: 1,  data: 32'h07060504, keep: 4'b1111, last: 1'b0};
        vecs[2] = '{beat: 20, data: 32'h53525150, keep: 4'b1111, last: 1'b0};
        vecs[3] = '{beat: 39, data: 32'h9F9E9D9C, keep: 4'b1111, last: 1'b0};
        vecs[4] = '{beat: 40, data: 32'h0000A1A0, keep: 4'b0011, last: 1'b1};

        #1;
        check("rst_valid",   64'(bus.out_valid), 64'd0);
        check("rst_data",    64'(bus.out_data),  64'd0);
        check("rst_keep",    64'(bus.out_keep),  64'd0);
        check("rst_last",    64'(bus.out_last),  64'd0);
        check("rst_busy",    64'(bus.busy),      64'd0);
        check("rst_overrun", 64'(bus.overrun),   64'd0);
        #20 reset = 1'b1;
        tick();

        // Basic frame, table vectors at selected beats
        bus.out_ready = 1'b1;
        start_frame(0);
        for (int b = 0; b < NB; b++) begin
            check_beat("basic", 0, b);
            check("basic_busy", 64'(bus.busy), 64'd1);
            for (int k = 0; k < 5; k++) begin
                if (vecs[k].beat == b) begin
                    check("vec_data", 64'(bus.out_data), 64'(vecs[k].data));
                    check("vec_keep", 64'(bus.out_keep), 64'(vecs[k].keep));
                    check("vec_last", 64'(bus.out_last), 64'(vecs[k].last));
                end
            end
            tick();
        end
        check("basic_idle_valid", 64'(bus.out_valid), 64'd0);
        check("basic_idle_busy",  64'(bus.busy),      64'd0);

        // Backpressure with out_ready pattern 1,0,0,1
        pat = 4'b1001;
        start_frame(0);
        nx = 0; cyc = 0; stalled = 1'b0;
        held_d = '0; held_k = '0; held_l = 1'b0;
        while (nx < NB && cyc < 400) begin
            bus.out_ready = pat[cyc % 4];
            check("bp_valid", 64'(bus.out_valid), 64'd1);
            if (stalled) begin
                check("bp_hold_data", 64'(bus.out_data), 64'(held_d));
                check("bp_hold_keep", 64'(bus.out_keep), 64'(held_k));
                check("bp_hold_last", 64'(bus.out_last), 64'(held_l));
            end
            if (bus.out_ready) begin
                check("bp_data", 64'(bus.out_data), 64'(exp_data(0, nx)));
                check("bp_keep", 64'(bus.out_keep), 64'(exp_keep(nx)));
                check("bp_last", 64'(bus.out_last), 64'(nx == NB - 1));
                nx++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held_d = bus.out_data;
                held_k = bus.out_keep;
                held_l = bus.out_last;
            end
            cyc++;
            tick();
        end
        check("bp_count", 64'(nx), 64'(NB));
        check("bp_idle_valid", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b1;

`ifndef FME_SAIDA_DOUBLE_BUF_EN
        // Single buffer: fme_done during beat 10 is dropped and flags overrun
        start_frame(0);
        for (int b = 0; b < NB; b++) begin
            check_beat("ovr", 0, b);
            if (b == 11) check("ovr_set", 64'(bus.overrun), 64'd1);
            if (b == 10) begin
                load(0, 1'b1);
                bus.fme_done = 1'b1;
            end
            tick();
            bus.fme_done = 1'b0;
        end
        check("ovr_idle_valid", 64'(bus.out_valid), 64'd0);
        check("ovr_sticky",     64'(bus.overrun),   64'd1);
        bus.clear_erro = 1'b1;
        tick();
        bus.clear_erro = 1'b0;
        check("ovr_clear", 64'(bus.overrun), 64'd0);

        // Set and clear in the same cycle: set wins
        start_frame(0);
        for (int b = 0; b < NB; b++) begin
            check_beat("ovr2", 0, b);
            if (b == 4) check("ovr_set_wins", 64'(bus.overrun), 64'd1);
            if (b == 3) begin
                bus.fme_done   = 1'b1;
                bus.clear_erro = 1'b1;
            end
            tick();
            bus.fme_done   = 1'b0;
            bus.clear_erro = 1'b0;
        end
        bus.clear_erro = 1'b1;
        tick();
        bus.clear_erro = 1'b0;
        check("ovr2_clear", 64'(bus.overrun), 64'd0);
`else
        // Double buffer: beat 5 fills pending, beat 30 overruns, 82 contiguous beats
        start_frame(0);
        for (int b = 0; b < 2 * NB; b++) begin
            check_beat("dbuf", (b < NB) ? 0 : 50, b % NB);
            if (b == 6)  check("dbuf_no_ovr", 64'(bus.overrun), 64'd0);
            if (b == 31) check("dbuf_ovr",    64'(bus.overrun), 64'd1);
            if (b == 5) begin
                load(50, 1'b0);
                bus.fme_done = 1'b1;
            end
            if (b == 30) begin
                load(99, 1'b0);
                bus.fme_done = 1'b1;
            end
            tick();
            bus.fme_done = 1'b0;
        end
        check("dbuf_idle_valid", 64'(bus.out_valid), 64'd0);
        bus.clear_erro = 1'b1;
        tick();
        bus.clear_erro = 1'b0;
        check("dbuf_clear", 64'(bus.overrun), 64'd0);
`endif

        // Back-to-back: fme_done on the final-beat transfer
        start_frame(0);
        for (int b = 0; b < NB; b++) begin
            check_beat("b2b_a", 0, b);
            if (b == NB - 1) begin
                load(7, 1'b0);
                bus.fme_done = 1'b1;
            end
            tick();
            bus.fme_done = 1'b0;
        end
        for (int b = 0; b < NB; b++) begin
            check_beat("b2b_b", 7, b);
            tick();
        end
        check("b2b_overrun",    64'(bus.overrun),   64'd0);
        check("b2b_idle_valid", 64'(bus.out_valid), 64'd0);

        // Reset at beat 20 aborts the frame
        start_frame(0);
        for (int b = 0; b < 20; b++) tick();
        check_beat("rstmid_pre", 0, 20);
        reset = 1'b0;
        #1;
        check("rstmid_valid", 64'(bus.out_valid), 64'd0);
        check("rstmid_data",  64'(bus.out_data),  64'd0);
        check("rstmid_keep",  64'(bus.out_keep),  64'd0);
        check("rstmid_last",  64'(bus.out_last),  64'd0);
        check("rstmid_busy",  64'(bus.busy),      64'd0);
        tick();
        tick();
        #2 reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rstmid_post_valid", 64'(bus.out_valid), 64'd0);
        end
        start_frame(3);
        for (int b = 0; b < NB; b++) begin
            check_beat("rstmid_new", 3, b);
            tick();
        end
        check("rstmid_end_valid", 64'(bus.out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
